frontend_cmd_arbiter: RTL and testbench

Shares the single frontend command FIFO between `NUM_REQ` requesters (core ports) of the DRAM global controller. Round-robin arbitration at packet granularity: once granted, a requester owns the FIFO write port until its last beat is written. The block drives the FIFO write side (`wr_en`/data, honouring `full`) and flags packets that overrun the maximum length.

---
 rtl/frontend_command_definition_pkg.sv | 17 +
 rtl/rr_arbiter.sv | 37 +++
 rtl/frontend_cmd_arbiter.sv | 113 +++++++++++
 tb/tb_frontend_cmd_arbiter.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/frontend_command_definition_pkg.sv
// Shared constants and types for the frontend command path of the DRAM global controller.
// Default sizes match the single frontend command FIFO.
package frontend_command_definition_pkg;

    localparam int NUM_REQ   = 4;
    localparam int CMD_WIDTH = 32;
    localparam int MAX_BEATS = 8;
    localparam int REQ_ID_W  = $clog2(NUM_REQ);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    typedef logic [REQ_ID_W-1:0] req_id_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotate-priority picker: first asserted request at or after the pointer,
// wrapping around, reported as one-hot grant, binary index and an any-request flag.
module rr_arbiter #(
    parameter int N    = 4,
    parameter int ID_W = $clog2(N)
) (
    input  logic [N-1:0]    i_req,
    input  logic [ID_W-1:0] i_ptr,
    output logic [N-1:0]    o_grant,
    output logic [ID_W-1:0] o_idx,
    output logic            o_any
);

    logic [ID_W-1:0] cand;

    function automatic logic [ID_W-1:0] wrap_idx(input logic [ID_W-1:0] p, input int off);
        int s;
        s = (int'(p) + off) % N;
        return ID_W'(s);
    endfunction

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        cand    = '0;
        for (int i = 0; i < N; i++) begin
            cand = wrap_idx(i_ptr, i);
            if (!o_any && i_req[cand]) begin
                o_any         = 1'b1;
                o_grant[cand] = 1'b1;
                o_idx         = cand;
            end
        end
    end

endmodule

// File: rtl/frontend_cmd_arbiter.sv
// Packet-granular round-robin arbiter sharing the frontend command FIFO write port
// between NUM_REQ core ports; flags packets that run past MAX_BEATS without a last beat.
module frontend_cmd_arbiter #(
    parameter int NUM_REQ    = frontend_command_definition_pkg::NUM_REQ,
    parameter int DATA_WIDTH = frontend_command_definition_pkg::CMD_WIDTH,
    parameter int MAX_BEATS  = frontend_command_definition_pkg::MAX_BEATS,
    parameter int ID_W       = $clog2(NUM_REQ),
    parameter int CNT_W      = $clog2(MAX_BEATS + 1)
) (
    input  logic                                i_clk,
    input  logic                                i_rst_n,
    input  logic [NUM_REQ-1:0]                  i_req_valid,
    input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]  i_req_data,
    input  logic [NUM_REQ-1:0]                  i_req_last,
    output logic [NUM_REQ-1:0]                  o_req_ready,
    output logic                                o_fifo_wr_en,
    output logic [DATA_WIDTH-1:0]               o_fifo_data,
    input  logic                                i_fifo_full,
    output logic [ID_W-1:0]                     o_grant_id,
    output logic                                o_busy,
    output logic                                o_pkt_err
);

    import frontend_command_definition_pkg::*;

    arb_state_t         state, state_nxt;
    logic [ID_W-1:0]    rr_ptr;
    logic [CNT_W-1:0]   beat_cnt;
    logic [NUM_REQ-1:0] arb_grant;
    logic [ID_W-1:0]    arb_idx;
    logic               arb_any;
    logic               xfer;
    logic               pkt_end;
    logic               forced_end;

    rr_arbiter #(
        .N    (NUM_REQ),
        .ID_W (ID_W)
    ) u_rr_arbiter (
        .i_req   (i_req_valid),
        .i_ptr   (rr_ptr),
        .o_grant (arb_grant),
        .o_idx   (arb_idx),
        .o_any   (arb_any)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Ready depends only on ownership and FIFO space, never on the requester's valid.
    always_comb begin
        state_nxt    = state;
        o_req_ready  = '0;
        o_fifo_wr_en = 1'b0;
        o_fifo_data  = '0;
        o_busy       = 1'b0;
        xfer         = 1'b0;
        pkt_end      = 1'b0;
        forced_end   = 1'b0;
        unique case (state)
            IDLE: begin
                if (arb_any) begin
                    state_nxt = LOCKED;
                end
            end
            LOCKED: begin
                o_busy      = 1'b1;
                o_fifo_data = i_req_data[o_grant_id];
                if (!i_fifo_full) begin
                    o_req_ready[o_grant_id] = 1'b1;
                end
                xfer         = i_req_valid[o_grant_id] && !i_fifo_full;
                o_fifo_wr_en = xfer;
                forced_end   = xfer && !i_req_last[o_grant_id] &&
                               (beat_cnt == CNT_W'(MAX_BEATS - 1));
                pkt_end      = xfer && (i_req_last[o_grant_id] || forced_end);
                if (pkt_end) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Owner, beat count, rotation pointer and sticky overrun flag.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_grant_id <= '0;
            rr_ptr     <= '0;
            beat_cnt   <= '0;
            o_pkt_err  <= 1'b0;
        end else begin
            if (state == IDLE && arb_any) begin
                o_grant_id <= arb_idx;
            end
            if (pkt_end) begin
                beat_cnt <= '0;
                rr_ptr   <= (o_grant_id == ID_W'(NUM_REQ - 1)) ? '0 : o_grant_id + ID_W'(1);
            end else if (xfer) begin
                beat_cnt <= beat_cnt + CNT_W'(1);
            end
            if (forced_end) begin
                o_pkt_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_frontend_cmd_arbiter.sv
// Bench for frontend_cmd_arbiter: fixed vector table, directed multi-cycle scenarios and
// randomized traffic compared cycle by cycle with a behavioural model of the arbitration rules.
module tb_frontend_cmd_arbiter;

    localparam int N  = 4;
    localparam int W  = 32;
    localparam int MB = 8;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [N-1:0]       valid = '0;
    logic [N-1:0][W-1:0] data = '0;
    logic [N-1:0]       last = '0;
    logic               full = 1'b0;
    logic [N-1:0]       o_req_ready;
    logic               o_fifo_wr_en;
    logic [W-1:0]       o_fifo_data;
    logic [1:0]         o_grant_id;
    logic               o_busy;
    logic               o_pkt_err;

    frontend_cmd_arbiter #(.NUM_REQ(N), .DATA_WIDTH(W), .MAX_BEATS(MB)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_req_valid  (valid),
        .i_req_data   (data),
        .i_req_last   (last),
        .o_req_ready  (o_req_ready),
        .o_fifo_wr_en (o_fifo_wr_en),
        .o_fifo_data  (o_fifo_data),
        .i_fifo_full  (full),
        .o_grant_id   (o_grant_id),
        .o_busy       (o_busy),
        .o_pkt_err    (o_pkt_err)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [3:0]  v;
        logic [3:0]  l;
        logic        f;
        logic [31:0] d;
        logic [3:0]  er;
        logic        ew;
        logic [31:0] ed;
        logic        eb;
        logic [1:0]  eg;
        logic        cg;
        logic        ee;
    } vec_t;

    vec_t tbl[14];

    // Driver queues per requester and the behavioural model state
    int unsigned qd[N][$];
    bit          ql[N][$];
    bit          hold[N];
    bit          rnd_mode = 0;
    bit          full_force = 0;
    logic [N-1:0] rdy_s;
    int          m_owner, m_ptr, m_cnt;
    bit          m_err;
    int unsigned wlog[$];
    int          wcyc[$];
    int          wown[$];
    int          cyc;

    task automatic model_reset();
        m_owner = -1;
        m_ptr   = 0;
        m_cnt   = 0;
        m_err   = 0;
    endtask

    function automatic bit pending();
        for (int i = 0; i < N; i++) if (qd[i].size() > 0) return 1;
        return 0;
    endfunction

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            if (qd[i].size() > 0 && (hold[i] || !rnd_mode || $urandom_range(3) != 0)) begin
                valid[i] = 1'b1;
                data[i]  = qd[i][0];
                last[i]  = ql[i][0];
            end else begin
                valid[i] = 1'b0;
                data[i]  = $urandom;
                last[i]  = 1'($urandom_range(1));
            end
        end
        full = rnd_mode ? ($urandom_range(3) == 0) : full_force;
    endtask

    task automatic check();
        logic [N-1:0] er;
        bit ew;
        er = '0;
        ew = 0;
        if (m_owner >= 0) begin
            er = full ? '0 : (N'(1) << m_owner);
            ew = valid[m_owner] && !full;
        end
        chk("ready", o_req_ready, er);
        chk("wr_en", o_fifo_wr_en, ew);
        chk("busy", o_busy, m_owner >= 0);
        chk("pkt_err", o_pkt_err, m_err);
        if (m_owner >= 0) chk("grant_id", o_grant_id, m_owner);
        if (ew) chk("data", o_fifo_data, data[m_owner]);
        if (o_fifo_wr_en) begin
            wlog.push_back(o_fifo_data);
            wcyc.push_back(cyc);
            wown.push_back(int'(o_grant_id));
        end
        rdy_s = o_req_ready;
    endtask

    task automatic advance();
        bit found;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (valid[i] && rdy_s[i]) begin
                void'(qd[i].pop_front());
                void'(ql[i].pop_front());
                hold[i] = 0;
            end else begin
                hold[i] = valid[i];
            end
        end
        if (m_owner < 0) begin
            found = 0;
            for (int k = 0; k < N; k++) begin
                if (!found && valid[(m_ptr + k) % N]) begin
                    found   = 1;
                    m_owner = (m_ptr + k) % N;
                end
            end
        end else if (valid[m_owner] && !full) begin
            m_cnt++;
            if (last[m_owner] || m_cnt == MB) begin
                if (!last[m_owner]) m_err = 1;
                m_ptr   = (m_owner + 1) % N;
                m_owner = -1;
                m_cnt   = 0;
            end
        end
        cyc++;
    endtask

    task automatic step();
        drive();
        #3;
        check();
        advance();
    endtask

    task automatic clear_bench();
        for (int i = 0; i < N; i++) begin
            qd[i].delete();
            ql[i].delete();
            hold[i] = 0;
        end
        valid = '0;
        wlog.delete();
        wcyc.delete();
        wown.delete();
        cyc = 0;
        model_reset();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_bench();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic push_pkt(input int r, input int len, input int unsigned base);
        for (int b = 0; b < len; b++) begin
            qd[r].push_back(base + b);
            ql[r].push_back(b == len - 1);
        end
    endtask

    task automatic drain(input string name, input int bound);
        int n;
        n = 0;
        while ((pending() || m_owner >= 0) && n < bound) begin
            step();
            n++;
        end
        chk({name, "_drain_in_time"}, n < bound, 1);
    endtask

    initial begin
        // cycle-level vectors from reset, requester i sees data d + i*0x100
        tbl[0]  = '{4'b0001, 4'b0001, 1'b0, 32'hA5,   4'b0000, 1'b0, 32'h0,   1'b0, 2'd0, 1'b1, 1'b0};
        tbl[1]  = '{4'b0001, 4'b0001, 1'b0, 32'hA5,   4'b0001, 1'b1, 32'hA5,  1'b1, 2'd0, 1'b1, 1'b0};
        tbl[2]  = '{4'b0000, 4'b0000, 1'b0, 32'h0,    4'b0000, 1'b0, 32'h0,   1'b0, 2'd0, 1'b0, 1'b0};
        tbl[3]  = '{4'b0100, 4'b0000, 1'b0, 32'h1000, 4'b0000, 1'b0, 32'h0,   1'b0, 2'd0, 1'b0, 1'b0};
        tbl[4]  = '{4'b0100, 4'b0000, 1'b0, 32'h1000, 4'b0100, 1'b1, 32'h1200, 1'b1, 2'd2, 1'b1, 1'b0};
        tbl[5]  = '{4'b0100, 4'b0000, 1'b1, 32'h1000, 4'b0000, 1'b0, 32'h0,   1'b1, 2'd2, 1'b1, 1'b0};
        tbl[6]  = '{4'b0100, 4'b0000, 1'b1, 32'h1000, 4'b0000, 1'b0, 32'h0,   1'b1, 2'd2, 1'b1, 1'b0};
        tbl[7]  = '{4'b0100, 4'b0000, 1'b1, 32'h1000, 4'b0000, 1'b0, 32'h0,   1'b1, 2'd2, 1'b1, 1'b0};
        tbl[8]  = '{4'b0100, 4'b0100, 1'b0, 32'h2000, 4'b0100, 1'b1, 32'h2200, 1'b1, 2'd2, 1'b1, 1'b0};
        tbl[9]  = '{4'b0000, 4'b0000, 1'b0, 32'h0,    4'b0000, 1'b0, 32'h0,   1'b0, 2'd0, 1'b0, 1'b0};
        tbl[10] = '{4'b1000, 4'b0000, 1'b0, 32'h30,   4'b0000, 1'b0, 32'h0,   1'b0, 2'd0, 1'b0, 1'b0};
        tbl[11] = '{4'b0000, 4'b0000, 1'b0, 32'h30,   4'b1000, 1'b0, 32'h0,   1'b1, 2'd3, 1'b1, 1'b0};
        tbl[12] = '{4'b1000, 4'b1000, 1'b0, 32'h30,   4'b1000, 1'b1, 32'h330, 1'b1, 2'd3, 1'b1, 1'b0};
        tbl[13] = '{4'b0000, 4'b0000, 1'b0, 32'h0,    4'b0000, 1'b0, 32'h0,   1'b0, 2'd0, 1'b0, 1'b0};

        clear_bench();
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int k = 0; k < 14; k++) begin
            valid = tbl[k].v;
            last  = tbl[k].l;
            full  = tbl[k].f;
            for (int i = 0; i < N; i++) data[i] = tbl[k].d + 32'(i * 'h100);
            #3;
            chk($sformatf("vec%0d_ready", k), o_req_ready, tbl[k].er);
            chk($sformatf("vec%0d_wr_en", k), o_fifo_wr_en, tbl[k].ew);
            if (tbl[k].ew) chk($sformatf("vec%0d_data", k), o_fifo_data, tbl[k].ed);
            chk($sformatf("vec%0d_busy", k), o_busy, tbl[k].eb);
            if (tbl[k].cg) chk($sformatf("vec%0d_grant_id", k), o_grant_id, tbl[k].eg);
            chk($sformatf("vec%0d_pkt_err", k), o_pkt_err, tbl[k].ee);
            @(posedge clk);
            #1;
        end

        // all four requesters with 2-beat packets from reset
        do_reset();
        for (int i = 0; i < N; i++) push_pkt(i, 2, 32'(i * 16));
        drain("four_way", 60);
        chk("four_way_count", wlog.size(), 8);
        if (wlog.size() == 8) begin
            for (int k = 0; k < 8; k++) begin
                chk($sformatf("four_way_data%0d", k), wlog[k], 32'((k / 2) * 16 + (k % 2)));
                chk($sformatf("four_way_cycle%0d", k), wcyc[k], (k / 2) * 3 + 1 + (k % 2));
            end
        end

        // 10-beat packet from requester 1: forced split after 8 beats
        do_reset();
        push_pkt(1, 10, 32'h100);
        drain("overrun", 60);
        chk("overrun_count", wlog.size(), 10);
        if (wlog.size() == 10) begin
            for (int k = 0; k < 10; k++) chk($sformatf("overrun_data%0d", k), wlog[k], 32'h100 + k);
            chk("overrun_beat8_cycle", wcyc[7], 8);
            chk("overrun_beat9_cycle", wcyc[8], 10);
        end
        chk("overrun_err_sticky", o_pkt_err, 1);

        // reset asserted while beat 2 of a 4-beat packet is presented
        push_pkt(1, 4, 32'h200);
        step();
        step();
        drive();
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_ready", o_req_ready, 0);
        chk("rst_wr_en", o_fifo_wr_en, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_pkt_err", o_pkt_err, 0);
        chk("rst_grant_id", o_grant_id, 0);
        @(posedge clk);
        #1;
        clear_bench();
        rst_n = 1'b1;
        push_pkt(1, 1, 32'h11);
        push_pkt(3, 1, 32'h33);
        drain("post_reset", 30);
        chk("post_reset_count", wown.size(), 2);
        if (wown.size() == 2) begin
            chk("post_reset_first_owner", wown[0], 1);
            chk("post_reset_second_owner", wown[1], 3);
        end

        // requesters 0 and 3 continuously requesting must alternate
        do_reset();
        for (int p = 0; p < 3; p++) begin
            push_pkt(0, 1, 32'h500 + p);
            push_pkt(3, 1, 32'h800 + p);
        end
        drain("alternate", 60);
        chk("alternate_count", wown.size(), 6);
        if (wown.size() == 6) begin
            for (int k = 0; k < 6; k++) chk($sformatf("alternate_owner%0d", k), wown[k], (k % 2) ? 3 : 0);
        end

        // randomized traffic with FIFO-full and valid gaps
        do_reset();
        rnd_mode = 1;
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < N; i++) begin
                if (qd[i].size() == 0 && $urandom_range(3) == 0)
                    push_pkt(i, int'($urandom_range(1, 11)), $urandom);
            end
            step();
        end
        rnd_mode = 0;
        full_force = 0;
        drain("random", 400);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
